// File: rtl/logic_axi4_stream_downsizer_unit_if.sv
// AXI4-Stream bundle shared by the wide and narrow sides of the downsizer.
// Disabled tdest/tid collapse to a single bit that the producer ties to zero.
interface logic_axi4_stream_if #(
  parameter int TDATA_BYTES = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TID_WIDTH   = 1
);
  localparam int DEST_W = (TDEST_WIDTH > 0) ? TDEST_WIDTH : 1;
  localparam int ID_W   = (TID_WIDTH > 0) ? TID_WIDTH : 1;

  logic                     tvalid;
  logic                     tready;
  logic [TDATA_BYTES*8-1:0] tdata;
  logic [TDATA_BYTES-1:0]   tkeep;
  logic [TDATA_BYTES-1:0]   tstrb;
  logic                     tlast;
  logic [TUSER_WIDTH-1:0]   tuser;
  logic [DEST_W-1:0]        tdest;
  logic [ID_W-1:0]          tid;

  modport rx (input tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid, output tready);
  modport tx (output tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid, input tready);
endinterface

// File: rtl/logic_axi4_stream_downsizer_unit.sv
// Splits each wide AXI4-Stream beat into DOWNSIZE narrow beats, lowest slice first,
// optionally cutting the beat short once every remaining slice has tkeep all zero.
//
// state        | meaning
// FSM_IDLE     | buffer empty, rx ready, tx idle
// FSM_DOWNSIZE | buffer holds a wide beat, tx presents slice index_q
module logic_axi4_stream_downsizer_unit #(
  parameter int RX_TDATA_BYTES = 1,
  parameter int TX_TDATA_BYTES = 1,
  parameter int RX_TUSER_WIDTH = 1,
  parameter int TX_TUSER_WIDTH = 1,
  parameter int TDEST_WIDTH    = 1,
  parameter int TID_WIDTH      = 1,
  parameter int USE_TLAST      = 1,
  parameter int USE_TKEEP      = 1,
  parameter int USE_TSTRB      = 1,
  parameter int DOWNSIZE       = RX_TDATA_BYTES / TX_TDATA_BYTES,
  parameter int INDEX_WIDTH    = (DOWNSIZE >= 2) ? $clog2(DOWNSIZE) : 1
) (
  input  logic              aclk,
  input  logic              areset_n,
  logic_axi4_stream_if.rx   rx,
  logic_axi4_stream_if.tx   tx
);
  localparam int TXW        = TX_TDATA_BYTES * 8;
  localparam int RXW        = RX_TDATA_BYTES * 8;
  localparam int DEST_W     = (TDEST_WIDTH > 0) ? TDEST_WIDTH : 1;
  localparam int ID_W       = (TID_WIDTH > 0) ? TID_WIDTH : 1;
  localparam bit USER_SPLIT = (RX_TUSER_WIDTH != TX_TUSER_WIDTH);

  if ((TX_TDATA_BYTES > RX_TDATA_BYTES) || (RX_TDATA_BYTES % TX_TDATA_BYTES != 0)) begin : g_drc_bytes
    $error("RX_TDATA_BYTES must be an exact multiple of TX_TDATA_BYTES");
  end
  if ((TX_TUSER_WIDTH > RX_TUSER_WIDTH) ||
      ((RX_TUSER_WIDTH != TX_TUSER_WIDTH) && (RX_TUSER_WIDTH != DOWNSIZE * TX_TUSER_WIDTH))) begin : g_drc_user
    $error("tuser widths must be equal or RX_TUSER_WIDTH == DOWNSIZE * TX_TUSER_WIDTH");
  end

  typedef enum logic {FSM_IDLE, FSM_DOWNSIZE} state_t;

  state_t                   state_q;
  logic [INDEX_WIDTH-1:0]   index_q;
  logic                     tvalid_q;

  logic [RXW-1:0]            data_q;
  logic [RX_TDATA_BYTES-1:0] keep_q;
  logic [RX_TDATA_BYTES-1:0] strb_q;
  logic [RX_TUSER_WIDTH-1:0] user_q;
  logic [DEST_W-1:0]         dest_q;
  logic [ID_W-1:0]           id_q;
  logic                      last_q;

  logic upper_null;
  logic slice_last;
  logic rx_ready;
  logic capture;

  always_comb begin
    upper_null = 1'b1;
    for (int k = 0; k < DOWNSIZE; k++) begin
      if ((k > int'(index_q)) && (|keep_q[k*TX_TDATA_BYTES +: TX_TDATA_BYTES])) begin
        upper_null = 1'b0;
      end
    end
    slice_last = (index_q == INDEX_WIDTH'(DOWNSIZE - 1)) || ((USE_TKEEP != 0) && upper_null);
  end

  // rx.tready follows tx.tready combinationally so a new wide beat lands with zero bubbles
  assign rx_ready  = (state_q == FSM_IDLE) || (tx.tready && slice_last);
  assign rx.tready = rx_ready;
  assign capture   = rx.tvalid && rx_ready;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q  <= FSM_IDLE;
      index_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      case (state_q)
        FSM_IDLE: begin
          if (rx.tvalid) begin
            state_q  <= FSM_DOWNSIZE;
            tvalid_q <= 1'b1;
            index_q  <= '0;
          end
        end
        FSM_DOWNSIZE: begin
          if (tx.tready) begin
            if (!slice_last) begin
              index_q <= index_q + 1'b1;
            end else begin
              index_q <= '0;
              if (!rx.tvalid) begin
                state_q  <= FSM_IDLE;
                tvalid_q <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

  // Payload is a don't-care while tx.tvalid is low, so the buffer carries no reset.
  always_ff @(posedge aclk) begin
    if (capture) begin
      data_q <= rx.tdata;
      keep_q <= rx.tkeep;
      strb_q <= rx.tstrb;
      user_q <= rx.tuser;
      dest_q <= rx.tdest;
      id_q   <= rx.tid;
      last_q <= rx.tlast;
    end
  end

  assign tx.tvalid = tvalid_q;
  assign tx.tdata  = data_q[index_q*TXW +: TXW];
  assign tx.tkeep  = (USE_TKEEP != 0) ? keep_q[index_q*TX_TDATA_BYTES +: TX_TDATA_BYTES] : '1;
  assign tx.tstrb  = (USE_TSTRB != 0) ? strb_q[index_q*TX_TDATA_BYTES +: TX_TDATA_BYTES] : '1;
  assign tx.tlast  = (USE_TLAST != 0) ? (last_q && slice_last) : 1'b1;
  assign tx.tdest  = (TDEST_WIDTH > 0) ? dest_q : '0;
  assign tx.tid    = (TID_WIDTH > 0) ? id_q : '0;

  if (USER_SPLIT) begin : g_user_split
    assign tx.tuser = user_q[index_q*TX_TUSER_WIDTH +: TX_TUSER_WIDTH];
  end else begin : g_user_pass
    assign tx.tuser = user_q;
  end
endmodule

// File: tb/tb_logic_axi4_stream_downsizer_unit.sv
// Bench for the 4-byte to 1-byte stream downsizer with split tuser:
// directed latency/throughput/tkeep/reset steps, then random traffic against a slice-list model.
module tb_logic_axi4_stream_downsizer_unit;
  logic aclk = 1'b0;
  logic areset_n = 1'b0;
  always #5 aclk = ~aclk;

  logic_axi4_stream_if #(.TDATA_BYTES(4), .TUSER_WIDTH(4), .TDEST_WIDTH(2), .TID_WIDTH(3)) rx_if ();
  logic_axi4_stream_if #(.TDATA_BYTES(1), .TUSER_WIDTH(1), .TDEST_WIDTH(2), .TID_WIDTH(3)) tx_if ();

  logic_axi4_stream_downsizer_unit #(
    .RX_TDATA_BYTES(4), .TX_TDATA_BYTES(1), .RX_TUSER_WIDTH(4), .TX_TUSER_WIDTH(1),
    .TDEST_WIDTH(2), .TID_WIDTH(3), .USE_TLAST(1), .USE_TKEEP(1), .USE_TSTRB(1)
  ) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .rx       (rx_if),
    .tx       (tx_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0] d;
    logic       k;
    logic       s;
    logic       u;
    logic [1:0] dest;
    logic [2:0] id;
    logic       l;
  } slice_t;

  slice_t exp_q[$];
  bit     sb_en    = 1'b0;
  bit     rdy_rand = 1'b0;
  int     n_pushed = 0;
  int     n_seen   = 0;

  function automatic slice_t obs_slice();
    slice_t o;
    o.d    = tx_if.tdata;
    o.k    = tx_if.tkeep[0];
    o.s    = tx_if.tstrb[0];
    o.u    = tx_if.tuser[0];
    o.dest = tx_if.tdest;
    o.id   = tx_if.tid;
    o.l    = tx_if.tlast;
    return o;
  endfunction

  // Reference: emit slices up to the highest kept byte (at least one), tlast on the final one.
  task automatic model_push(input logic [31:0] d, input logic [3:0] k, input logic [3:0] s,
                            input logic [3:0] u, input logic [1:0] dest, input logic [2:0] id,
                            input logic l);
    int n = 1;
    slice_t e;
    for (int i = 0; i < 4; i++) if (k[i]) n = i + 1;
    for (int i = 0; i < n; i++) begin
      e.d = d[8*i +: 8];
      e.k = k[i];
      e.s = s[i];
      e.u = u[i];
      e.dest = dest;
      e.id = id;
      e.l = l && (i == n - 1);
      exp_q.push_back(e);
      n_pushed++;
    end
  endtask

  always @(posedge aclk) begin
    #1;
    tx_if.tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  slice_t stall_val;
  bit     stall_prev = 1'b0;
  always @(negedge aclk) begin
    if (!sb_en || !areset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_tvalid", tx_if.tvalid, 1);
        chk("stall_payload", obs_slice(), stall_val);
      end
      if (tx_if.tvalid && tx_if.tready) begin
        n_seen++;
        if (exp_q.size() == 0) chk("sb_unexpected_beat", tx_if.tvalid, 0);
        else chk("sb_slice", obs_slice(), exp_q.pop_front());
      end
      stall_prev = tx_if.tvalid && !tx_if.tready;
      stall_val  = obs_slice();
    end
  end

  task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic [3:0] s,
                       input logic [3:0] u, input logic [1:0] dest, input logic [2:0] id,
                       input logic l);
    rx_if.tdata = d;  rx_if.tkeep = k;   rx_if.tstrb = s; rx_if.tuser = u;
    rx_if.tdest = dest; rx_if.tid = id; rx_if.tlast = l; rx_if.tvalid = 1'b1;
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] beat_data(input int b);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = 8'(8'h40 + 4*b + i);
    return v;
  endfunction

  initial begin
    logic [3:0] u1;
    logic [31:0] rd;
    logic [3:0]  rk, rs, ru;
    logic [1:0]  rdest;
    logic [2:0]  rid;
    logic        rl, hs;
    int          bi, waited;

    rx_if.tvalid = 1'b0;
    drive(32'h0, 4'h0, 4'h0, 4'h0, 2'd0, 3'd0, 1'b0);
    rx_if.tvalid = 1'b0;

    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_tx_tvalid", tx_if.tvalid, 0);
    chk("rst_rx_tready", rx_if.tready, 1);
    step();
    areset_n = 1'b1;
    step();

    // single beat, one slice per cycle, tuser split per slice
    u1 = 4'b1010;
    drive(32'h44332211, 4'hF, 4'hF, u1, 2'd2, 3'd5, 1'b1);
    @(negedge aclk);
    chk("t1_idle_rx_tready", rx_if.tready, 1);
    chk("t1_idle_tvalid", tx_if.tvalid, 0);
    step();
    rx_if.tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      chk("t1_tvalid", tx_if.tvalid, 1);
      chk("t1_tdata", tx_if.tdata, 32'(8'h11 * (k + 1)));
      chk("t1_tlast", tx_if.tlast, 32'(k == 3));
      chk("t1_tuser", tx_if.tuser, 32'(u1[k]));
      chk("t1_tdest", tx_if.tdest, 2);
      chk("t1_tid", tx_if.tid, 5);
      chk("t1_rx_tready", rx_if.tready, 32'(k == 3));
      step();
    end
    @(negedge aclk);
    chk("t1_done_tvalid", tx_if.tvalid, 0);
    step();

    // three back-to-back beats, no bubbles
    bi = 0;
    drive(beat_data(0), 4'hF, 4'hF, 4'h0, 2'd0, 3'd0, 1'b0);
    for (int c = 0; c <= 12; c++) begin
      @(negedge aclk);
      hs = rx_if.tready && rx_if.tvalid;
      if (c == 0) begin
        chk("t2_idle_rx_tready", rx_if.tready, 1);
      end else begin
        chk("t2_tvalid", tx_if.tvalid, 1);
        chk("t2_tdata", tx_if.tdata, 32'(8'h40 + c - 1));
        chk("t2_rx_tready", rx_if.tready, 32'(((c - 1) % 4) == 3));
      end
      step();
      if (hs) begin
        bi++;
        if (bi < 3) drive(beat_data(bi), 4'hF, 4'hF, 4'h0, 2'd0, 3'd0, 1'(bi == 2));
        else rx_if.tvalid = 1'b0;
      end
    end
    @(negedge aclk);
    chk("t2_done_tvalid", tx_if.tvalid, 0);
    step();

    // tkeep 0x3 truncates to two slices; a tkeep 0x0 beat follows with no bubble
    drive(32'h44332211, 4'h3, 4'h3, 4'h0, 2'd1, 3'd1, 1'b1);
    @(negedge aclk);
    chk("t3_idle_rx_tready", rx_if.tready, 1);
    step();
    drive(32'hA5A5A5A5, 4'h0, 4'h0, 4'h0, 2'd1, 3'd1, 1'b1);
    @(negedge aclk);
    chk("t3_s0_tdata", tx_if.tdata, 8'h11);
    chk("t3_s0_tkeep", tx_if.tkeep, 1);
    chk("t3_s0_tlast", tx_if.tlast, 0);
    chk("t3_s0_rx_tready", rx_if.tready, 0);
    step();
    @(negedge aclk);
    chk("t3_s1_tdata", tx_if.tdata, 8'h22);
    chk("t3_s1_tlast", tx_if.tlast, 1);
    chk("t3_s1_rx_tready", rx_if.tready, 1);
    step();
    rx_if.tvalid = 1'b0;
    @(negedge aclk);
    chk("t4_null_tvalid", tx_if.tvalid, 1);
    chk("t4_null_tkeep", tx_if.tkeep, 0);
    chk("t4_null_tlast", tx_if.tlast, 1);
    chk("t4_null_tdata", tx_if.tdata, 8'hA5);
    step();
    @(negedge aclk);
    chk("t4_done_tvalid", tx_if.tvalid, 0);
    step();

    // reset in the middle of a beat
    drive(32'hDDCCBBAA, 4'hF, 4'hF, 4'h0, 2'd0, 3'd0, 1'b1);
    step();
    rx_if.tvalid = 1'b0;
    step();
    @(negedge aclk);
    chk("t5_s1_tdata", tx_if.tdata, 8'hBB);
    #2;
    areset_n = 1'b0;
    #1;
    chk("t5_rst_tvalid", tx_if.tvalid, 0);
    chk("t5_rst_rx_tready", rx_if.tready, 1);
    step();
    areset_n = 1'b1;
    drive(32'h88776655, 4'hF, 4'hF, 4'h0, 2'd0, 3'd0, 1'b1);
    @(negedge aclk);
    chk("t5_idle_rx_tready", rx_if.tready, 1);
    step();
    rx_if.tvalid = 1'b0;
    @(negedge aclk);
    chk("t5_restart_tvalid", tx_if.tvalid, 1);
    chk("t5_restart_tdata", tx_if.tdata, 8'h55);
    repeat (5) step();

    // random traffic and backpressure against the slice-list model
    sb_en = 1'b1;
    rdy_rand = 1'b1;
    for (int p = 0; p < 200; p++) begin
      repeat ($urandom_range(0, 2)) step();
      rd = $urandom();
      rk = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom());
      rs = 4'($urandom());
      ru = 4'($urandom());
      rdest = 2'($urandom());
      rid = 3'($urandom());
      rl = 1'($urandom());
      drive(rd, rk, rs, ru, rdest, rid, rl);
      hs = 1'b0;
      waited = 0;
      while (!hs && waited < 1000) begin
        @(negedge aclk);
        hs = rx_if.tready;
        if (hs) model_push(rd, rk, rs, ru, rdest, rid, rl);
        step();
        waited++;
      end
      chk("rand_rx_accept", hs, 1);
      rx_if.tvalid = 1'b0;
    end
    rdy_rand = 1'b0;
    waited = 0;
    while (exp_q.size() != 0 && waited < 2000) begin
      step();
      waited++;
    end
    repeat (2) step();
    @(negedge aclk);
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_tvalid", tx_if.tvalid, 0);
    chk("rand_slice_count", n_seen, n_pushed);
    sb_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
